// File: rtl/dmem_pkg.sv
// Shared types for the sized data memory: access sizes, FSM states and per-size byte masks.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Byte enables for an access of each size at lane 0, indexed by size_e.
  localparam logic [3:0][7:0] SIZE_MASK = {8'hFF, 8'h0F, 8'h03, 8'h01};

  // Lane bits that survive natural alignment of an access of the given size.
  function automatic logic [2:0] size_align(input size_e s);
    return ~(3'((4'd1 << s) - 4'd1));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte mask and lane-shifted write data, plus load extract and extend.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  size_e             size_i,
  input  logic              unsigned_i,
  input  logic [2:0]        lane_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   word_i,
  output logic [7:0]        be_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   rdata_o
);

  logic [XLEN-1:0] shifted;

  assign be_o    = SIZE_MASK[size_i] << lane_i;
  assign wdata_o = wdata_i << {lane_i, 3'b000};
  assign shifted = word_i >> {lane_i, 3'b000};

  always_comb begin
    rdata_o = shifted;
    unique case (size_i)
      SZ_B: rdata_o = unsigned_i ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                 : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      SZ_H: rdata_o = unsigned_i ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                 : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      SZ_W: rdata_o = unsigned_i ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                 : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressable sized data memory with valid/ready requests and configurable wait states.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_fault_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, uns_q;
  size_e           size_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            fault_q;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic            accept, enter_resp;
  logic            cur_we, cur_uns, fault;
  size_e           cur_size;
  logic [XLEN-1:0] cur_addr, cur_wdata;
  logic [2:0]      lane;
  logic [AW-1:0]   idx;
  logic [7:0]      be;
  logic [XLEN-1:0] wdata_sh, load_data;

  assign accept = (state_q == ST_IDLE) && req_valid_i;

  // With no wait states the array is accessed on the acceptance edge itself, so use live inputs.
  assign cur_we    = (state_q == ST_IDLE) ? req_we_i           : we_q;
  assign cur_uns   = (state_q == ST_IDLE) ? req_unsigned_i     : uns_q;
  assign cur_size  = (state_q == ST_IDLE) ? size_e'(req_size_i) : size_q;
  assign cur_addr  = (state_q == ST_IDLE) ? req_addr_i         : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? req_wdata_i        : wdata_q;

  assign lane = cur_addr[2:0] & size_align(cur_size);
  assign idx  = cur_addr[3+AW-1:3];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault = (|cur_addr[XLEN-1:3+AW]) || (|(cur_addr[2:0] & ~size_align(cur_size)));
`else
  assign fault = |cur_addr[XLEN-1:3+AW];
`endif

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .size_i     (cur_size),
    .unsigned_i (cur_uns),
    .lane_i     (lane),
    .wdata_i    (cur_wdata),
    .word_i     (mem_q[idx]),
    .be_o       (be),
    .wdata_o    (wdata_sh),
    .rdata_o    (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_d == ST_RESP);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        size_q  <= size_e'(req_size_i);
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (enter_resp) begin
        fault_q <= fault;
        rdata_q <= (fault || cur_we) ? '0 : load_data;
      end
    end
  end

  // Reset gates the commit so a store caught by reset never reaches the array.
  always_ff @(posedge clk_i) begin
    if (rst_ni && enter_resp && cur_we && !fault) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_fault_o = fault_q;

endmodule
